// File: rtl/change_dispenser_ctrl.sv
// Change payout sequencer: greedy 10/5-unit selection, hopper pulse/ack
// handshake with stall timeout, per-hopper inventory and shortfall report.
module change_dispenser_ctrl #(
  parameter int unsigned AMT_W   = 6,
  parameter int unsigned INV_W   = 6,
  parameter int unsigned INIT_10 = 20,
  parameter int unsigned INIT_5  = 20,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill,
  input  logic [INV_W-1:0] refill_10,
  input  logic [INV_W-1:0] refill_5,
  output logic             eject_10,
  output logic             eject_5,
  input  logic             hopper_ack,
  input  logic             clear_fault,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic             fault,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_5
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
  localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT,
    DONE,
    FAULT
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] remaining;
  logic             coin_10;
  logic [CNT_W-1:0] tcnt;

  // Add with clamp at the counter's full-scale value.
  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[INV_W] ? '1 : s[INV_W-1:0];
  endfunction

  // Payout FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      eject_10  <= 1'b0;
      eject_5   <= 1'b0;
      shortfall <= '0;
      fault     <= 1'b0;
      inv_10    <= INV_W'(INIT_10);
      inv_5     <= INV_W'(INIT_5);
      remaining <= '0;
      coin_10   <= 1'b0;
      tcnt      <= '0;
    end else begin
      done     <= 1'b0;
      eject_10 <= 1'b0;
      eject_5  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SELECT;
          end else if (refill) begin
            inv_10 <= sat_add(inv_10, refill_10);
            inv_5  <= sat_add(inv_5, refill_5);
          end
        end
        SELECT: begin
          tcnt <= '0;
          if (remaining >= TEN && inv_10 != '0) begin
            eject_10 <= 1'b1;
            coin_10  <= 1'b1;
            state    <= WAIT;
          end else if (remaining >= FIVE && inv_5 != '0) begin
            eject_5 <= 1'b1;
            coin_10 <= 1'b0;
            state   <= WAIT;
          end else begin
            done      <= 1'b1;
            shortfall <= remaining;
            state     <= DONE;
          end
        end
        WAIT: begin
          // An ack coinciding with the eject pulse itself is not a valid ack.
          if (!(eject_10 || eject_5) && hopper_ack) begin
            if (coin_10) begin
              remaining <= remaining - TEN;
              inv_10    <= inv_10 - INV_W'(1);
            end else begin
              remaining <= remaining - FIVE;
              inv_5     <= inv_5 - INV_W'(1);
            end
            state <= SELECT;
          end else if (tcnt == TO_LAST) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= FAULT;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        FAULT: begin
          if (clear_fault) begin
            fault     <= 1'b0;
            done      <= 1'b1;
            shortfall <= remaining;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench for change_dispenser_ctrl: vector table, hand-written
// corner sequences, and randomized payouts against a greedy-count model.
module tb_change_dispenser_ctrl;

  localparam int AMT_W   = 6;
  localparam int INV_W   = 6;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             refill;
  logic [INV_W-1:0] refill_10;
  logic [INV_W-1:0] refill_5;
  logic             eject_10;
  logic             eject_5;
  logic             hopper_ack;
  logic             clear_fault;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic             fault;
  logic [INV_W-1:0] inv_10;
  logic [INV_W-1:0] inv_5;

  int errors = 0;
  int checks = 0;

  change_dispenser_ctrl #(
    .AMT_W  (AMT_W),
    .INV_W  (INV_W),
    .INIT_10(20),
    .INIT_5 (20),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .refill     (refill),
    .refill_10  (refill_10),
    .refill_5   (refill_5),
    .eject_10   (eject_10),
    .eject_5    (eject_5),
    .hopper_ack (hopper_ack),
    .clear_fault(clear_fault),
    .busy       (busy),
    .done       (done),
    .shortfall  (shortfall),
    .fault      (fault),
    .inv_10     (inv_10),
    .inv_5      (inv_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int amount;
    int lat;
    int n10;
    int n5;
    int sf;
    int inv10;
    int inv5;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request from IDLE, act as the hopper (ack `lat` cycles after
  // each pulse), and return coin counts and the reported shortfall.
  task automatic payout(input int amt, input int lat, output int n10,
                        output int n5, output int sf, output int cyc,
                        output int ok);
    int  ack_cnt;
    int  perr;
    bit  seen5;
    n10 = 0; n5 = 0; sf = -1; cyc = 0; ok = 0;
    ack_cnt = 0; perr = 0; seen5 = 0;
    req_amount = AMT_W'(amt);
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 400 && ok == 0; i++) begin
      if (ack_cnt > 0) begin
        ack_cnt--;
        hopper_ack = (ack_cnt == 0);
      end else begin
        hopper_ack = 1'b0;
      end
      if (eject_10 || eject_5) begin
        if (ack_cnt > 0) perr++;
        if (eject_10 && eject_5) perr++;
        if (eject_10) begin
          n10++;
          if (seen5) perr++;
        end
        if (eject_5) begin
          n5++;
          seen5 = 1'b1;
        end
        ack_cnt = lat;
      end
      if (done) begin
        ok  = 1;
        sf  = int'(shortfall);
        cyc = i + 1;
      end else begin
        @(negedge clk);
      end
    end
    hopper_ack = 1'b0;
    chk("protocol", perr, 0);
    if (ok != 0) begin
      @(negedge clk);
      chk("ready_after_done", int'(req_ready), 1);
    end
  endtask

  task automatic wait_pulse(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (eject_10 || eject_5) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    int n10, n5, sf, cyc, ok;
    int m10, m5, e10, e5, esf, r, amt, lat, r10, r5, extra;
    bit seen;

    tbl[0] = '{25, 2, 2, 1, 0, 18, 19};
    tbl[1] = '{7,  1, 0, 1, 2, 18, 18};
    tbl[2] = '{0,  1, 0, 0, 0, 18, 18};
    tbl[3] = '{63, 3, 6, 0, 3, 12, 18};
    tbl[4] = '{63, 1, 6, 0, 3,  6, 18};
    tbl[5] = '{55, 2, 5, 1, 0,  1, 17};
    tbl[6] = '{30, 1, 1, 4, 0,  0, 13};
    tbl[7] = '{63, 2, 0, 12, 3, 0,  1};
    tbl[8] = '{14, 1, 0, 1, 9,  0,  0};
    tbl[9] = '{15, 1, 0, 0, 15, 0,  0};

    rst = 1'b1; req_valid = 1'b0; req_amount = '0; refill = 1'b0;
    refill_10 = '0; refill_5 = '0; hopper_ack = 1'b0; clear_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_shortfall", int'(shortfall), 0);
    chk("rst_inv_10", int'(inv_10), 20);
    chk("rst_inv_5", int'(inv_5), 20);
    rst = 1'b0;
    @(negedge clk);

    // Chained vectors from reset inventory down to empty hoppers.
    foreach (tbl[i]) begin
      payout(tbl[i].amount, tbl[i].lat, n10, n5, sf, cyc, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_n10", i), n10, tbl[i].n10);
      chk($sformatf("vec%0d_n5", i), n5, tbl[i].n5);
      chk($sformatf("vec%0d_shortfall", i), sf, tbl[i].sf);
      chk($sformatf("vec%0d_inv_10", i), int'(inv_10), tbl[i].inv10);
      chk($sformatf("vec%0d_inv_5", i), int'(inv_5), tbl[i].inv5);
      if (tbl[i].n10 + tbl[i].n5 == 0)
        chk($sformatf("vec%0d_fast_done", i), int'(cyc <= 3), 1);
    end

    // Refill together with a request: the request wins, refill dropped.
    refill = 1'b1; refill_10 = 7; refill_5 = 9;
    payout(0, 1, n10, n5, sf, cyc, ok);
    refill = 1'b0;
    chk("refill_vs_req_sf", sf, 0);
    chk("refill_vs_req_inv_10", int'(inv_10), 0);
    chk("refill_vs_req_inv_5", int'(inv_5), 0);

    // Hopper never acks: fault exactly TIMEOUT cycles after WAIT entry.
    do_reset();
    req_amount = 10; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_pulse(seen);
    chk("to_pulse_seen", int'(seen), 1);
    extra = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (eject_10 || eject_5) extra++;
      if (k == TIMEOUT - 1) chk("to_not_early", int'(fault), 0);
    end
    chk("to_fault", int'(fault), 1);
    chk("to_req_ready", int'(req_ready), 0);
    chk("to_busy", int'(busy), 0);
    chk("to_extra_pulses", extra, 0);
    refill = 1'b1; refill_10 = 5; refill_5 = 5;
    @(negedge clk);
    refill = 1'b0;
    chk("to_inv_10", int'(inv_10), 20);
    chk("to_inv_5", int'(inv_5), 20);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    chk("clr_done", int'(done), 1);
    chk("clr_shortfall", int'(shortfall), 10);
    chk("clr_fault", int'(fault), 0);
    @(negedge clk);
    chk("clr_req_ready", int'(req_ready), 1);
    chk("clr_done_low", int'(done), 0);

    // Reset asserted while waiting on the second coin of a payout.
    do_reset();
    req_amount = 25; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_pulse(seen);
    @(negedge clk);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    wait_pulse(seen);
    chk("rw_second_pulse", int'(seen), 1);
    chk("rw_inv_10_before", int'(inv_10), 19);
    rst = 1'b1;
    #1;
    chk("rw_req_ready", int'(req_ready), 1);
    chk("rw_busy", int'(busy), 0);
    chk("rw_eject", int'(eject_10 | eject_5), 0);
    chk("rw_inv_10", int'(inv_10), 20);
    chk("rw_inv_5", int'(inv_5), 20);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (eject_10 || eject_5 || done) extra++;
    end
    chk("rw_quiet_after", extra, 0);

    // Saturating refill.
    refill = 1'b1; refill_10 = 63; refill_5 = 63;
    @(negedge clk);
    refill = 1'b0;
    chk("sat_inv_10", int'(inv_10), 63);
    chk("sat_inv_5", int'(inv_5), 63);
    refill = 1'b1; refill_10 = 1; refill_5 = 1;
    @(negedge clk);
    refill = 1'b0;
    chk("sat_hold_10", int'(inv_10), 63);
    chk("sat_hold_5", int'(inv_5), 63);

    // Randomized payouts against greedy coin-count arithmetic.
    m10 = 63; m5 = 63;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        r10 = int'($urandom_range(0, 63));
        r5  = int'($urandom_range(0, 63));
        refill = 1'b1; refill_10 = INV_W'(r10); refill_5 = INV_W'(r5);
        @(negedge clk);
        refill = 1'b0;
        m10 = (m10 + r10 > 63) ? 63 : m10 + r10;
        m5  = (m5 + r5 > 63) ? 63 : m5 + r5;
        chk($sformatf("rnd%0d_refill_10", it), int'(inv_10), m10);
        chk($sformatf("rnd%0d_refill_5", it), int'(inv_5), m5);
      end
      amt = int'($urandom_range(0, 63));
      lat = int'($urandom_range(1, 6));
      e10 = (amt / 10 < m10) ? amt / 10 : m10;
      r   = amt - 10 * e10;
      e5  = (r / 5 < m5) ? r / 5 : m5;
      esf = r - 5 * e5;
      m10 -= e10;
      m5  -= e5;
      payout(amt, lat, n10, n5, sf, cyc, ok);
      chk($sformatf("rnd%0d_done", it), ok, 1);
      chk($sformatf("rnd%0d_n10", it), n10, e10);
      chk($sformatf("rnd%0d_n5", it), n5, e5);
      chk($sformatf("rnd%0d_shortfall", it), sf, esf);
      chk($sformatf("rnd%0d_inv_10", it), int'(inv_10), m10);
      chk($sformatf("rnd%0d_inv_5", it), int'(inv_5), m5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser_ctrl.md
Name: change_dispenser_ctrl

Overview:
- Sequences physical change payout for the vending machine.
- Accepts a change amount from the vending FSM and pays it out with greedy 10-unit/5-unit selection.
- Drives two coin hoppers using a pulse/acknowledge handshake.
- Tracks per-hopper coin inventory, reports any unpaid shortfall, and detects a stalled hopper by timeout.

Parameters:
- AMT_W, 6, width of change amount and shortfall.
- INV_W, 6, width of each hopper inventory counter.
- INIT_10, 20, 10-unit coin count loaded at reset.
- INIT_5, 20, 5-unit coin count loaded at reset.
- TIMEOUT, 15, max cycles in WAIT without hopper_ack before fault.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  change request present
- req_amount  in  AMT_W  change to pay, sampled on accept
- req_ready  out  1  controller can accept a request
- refill  in  1  add refill_10/refill_5 to inventory
- refill_10  in  INV_W  10-unit coins added
- refill_5  in  INV_W  5-unit coins added
- eject_10  out  1  one-cycle pulse: eject one 10-unit coin
- eject_5  out  1  one-cycle pulse: eject one 5-unit coin
- hopper_ack  in  1  active hopper confirms coin ejected
- clear_fault  in  1  leave FAULT state
- busy  out  1  payout in progress
- done  out  1  one-cycle pulse: payout finished
- shortfall  out  AMT_W  unpaid remainder, valid when done=1, held until next accept
- fault  out  1  hopper timeout, sticky
- inv_10  out  INV_W  current 10-unit inventory
- inv_5  out  INV_W  current 5-unit inventory

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, busy=0, done=0, eject_10=0, eject_5=0, shortfall=0, fault=0, inv_10=INIT_10, inv_5=INIT_5, state=IDLE.
- Reset mid-payout aborts immediately. Inventory returns to INIT values and no further pulses are issued.
- States: IDLE, SELECT, WAIT, DONE, FAULT.
- IDLE:
  - req_ready=1.
  - req_valid=1 latches remaining=req_amount and goes to SELECT. busy=1 from the next cycle.
  - refill=1 with no request adds to both counters, saturating at 2^INV_W-1.
  - refill and req_valid together: the request wins and the refill is dropped.
  - Refill is ignored in all states except IDLE.
- SELECT (one cycle):
  - If remaining>=10 and inv_10>0: pulse eject_10 next cycle, coin=10, go to WAIT.
  - Else if remaining>=5 and inv_5>0: pulse eject_5, coin=5, go to WAIT.
  - Else go to DONE.
- WAIT:
  - Timeout counter clears on entry.
  - hopper_ack is sampled only in WAIT and only after the cycle of the eject pulse.
  - On ack: remaining -= coin, decrement the matching inventory, return to SELECT.
  - If the counter reaches TIMEOUT with no ack: go to FAULT. remaining and inventory are unchanged.
  - At most one eject pulse is outstanding at any time.
- DONE (one cycle):
  - done=1, shortfall=remaining.
  - Return to IDLE. busy=0 and req_ready=1 in the following cycle.
  - A non-multiple of 5 always leaves shortfall = remainder mod 5 plus any inventory deficit.
- FAULT:
  - fault=1, busy=0, req_ready=0, no eject pulses.
  - clear_fault=1 goes to DONE with shortfall=remaining, then to IDLE, and clears fault.
- Arithmetic:
  - remaining never underflows, because a coin is chosen only if remaining>=coin.
  - Inventory never underflows, because a coin is chosen only if its count is >0.
- Zero-amount request: IDLE -> SELECT -> DONE, shortfall=0, no pulses.
- Per-coin cost: 2 cycles plus hopper latency.

Test Plan:
- Reset, inv 20/20, request 25, ack 2 cycles after each pulse -> eject_10, eject_10, eject_5 pulses; done with shortfall=0; inv_10=18, inv_5=19.
- inv_10=1, request 30 -> one eject_10 then four eject_5; shortfall=0; inv_10=0, inv_5 reduced by 4.
- Request 7 -> single eject_5; done with shortfall=2.
- Inventory drained to 0/0, request 15 -> no pulses; done with shortfall=15 within 3 cycles of accept.
- Request 10 with no hopper_ack -> fault=1 exactly TIMEOUT cycles after WAIT entry; req_ready=0. Then clear_fault -> done with shortfall=10, then back to IDLE.
- Assert rst while in WAIT -> all outputs at reset values the same cycle, inventory back to INIT. A refill of 63+63 at INIT 20/20 -> inv_10 and inv_5 saturate at 63.
